// File: rtl/acc_temp_pkg.sv
// Shared op codes, default sizes and helpers for the ACC/temp register unit.
package acc_temp_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LDA     = 3'd1,
        OP_LDT     = 3'd2,
        OP_XCH     = 3'd3,
        OP_CLR     = 3'd4,
        OP_CMC     = 3'd5,
        OP_SAVE    = 3'd6,
        OP_RESTORE = 3'd7
    } op_e;

    localparam int unsigned DEF_DATA_W     = 4;
    localparam int unsigned DEF_TEMP_DEPTH = 4;
    localparam int unsigned DEF_SAVE_DEPTH = 2;

    // Width of the temp register index; a single temp still gets a 1-bit select.
    function automatic int unsigned selWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/acc_save_stack.sv
// LIFO save stack for {carry, acc}; saturating pointer, no wrap-around.
module acc_save_stack
    import acc_temp_pkg::*;
#(
    parameter int unsigned W     = DEF_DATA_W + 1,
    parameter int unsigned DEPTH = DEF_SAVE_DEPTH
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         ovf,
    output logic         udf
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] ptrQ;
    logic [W-1:0]     mem [DEPTH];

    assign full  = (ptrQ == PTR_W'(DEPTH));
    assign empty = (ptrQ == '0);
    assign ovf   = push && full;
    assign udf   = pop && empty;
    // Top of stack sits one below the pointer.
    assign dout  = empty ? '0 : mem[IDX_W'(ptrQ - PTR_W'(1))];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptrQ <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[IDX_W'(ptrQ)] <= din;
            ptrQ              <= ptrQ + PTR_W'(1);
        end else if (pop && !empty) begin
            ptrQ <= ptrQ - PTR_W'(1);
        end
    end

endmodule

// File: rtl/acc_temp_unit.sv
// Accumulator, carry, indexed temp bank and ACC+carry save stack with sticky error flags.
module acc_temp_unit
    import acc_temp_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned TEMP_DEPTH = DEF_TEMP_DEPTH,
    parameter int unsigned SAVE_DEPTH = DEF_SAVE_DEPTH,
    localparam int unsigned SEL_W     = selWidth(TEMP_DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              opValid,
    input  logic [2:0]        opCode,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              aluCarry,
    input  logic [SEL_W-1:0]  tempSel,
    input  logic              errClr,
    output logic [DATA_W-1:0] accOut,
    output logic              carryOut,
    output logic [DATA_W-1:0] tempOut,
    output logic              accZero,
    output logic              saveFull,
    output logic              saveEmpty,
    output logic              errOvf,
    output logic              errUdf,
    output logic              errIll
);

    logic [DATA_W-1:0] accQ, accD;
    logic              carryQ, carryD;
    logic [DATA_W-1:0] tempQ [TEMP_DEPTH];
    logic [DATA_W-1:0] tempD [TEMP_DEPTH];
    logic              errOvfQ, errOvfD, errUdfQ, errUdfD, errIllQ, errIllD;
    logic              illNew, ovfNew, udfNew;
    logic              selOk;
    logic [DATA_W-1:0] tempRd;
    logic              push, pop;
    logic [DATA_W:0]   popData;
    op_e               op;

    assign op     = op_e'(opCode);
    assign selOk  = 32'(tempSel) < TEMP_DEPTH;
    assign tempRd = selOk ? tempQ[tempSel] : '0;
    assign push   = opValid && (op == OP_SAVE);
    assign pop    = opValid && (op == OP_RESTORE);

    acc_save_stack #(
        .W     (DATA_W + 1),
        .DEPTH (SAVE_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rstN  (rstN),
        .push  (push),
        .pop   (pop),
        .din   ({carryQ, accQ}),
        .dout  (popData),
        .full  (saveFull),
        .empty (saveEmpty),
        .ovf   (ovfNew),
        .udf   (udfNew)
    );

    always_comb begin
        accD   = accQ;
        carryD = carryQ;
        tempD  = tempQ;
        illNew = 1'b0;
        if (opValid) begin
            unique case (op)
                OP_NOP: ;
                OP_LDA: begin
                    accD   = aluResult;
                    carryD = aluCarry;
                end
                OP_LDT: begin
                    if (selOk) tempD[tempSel] = aluResult;
                    else       illNew = 1'b1;
                end
                OP_XCH: begin
                    if (selOk) begin
                        accD           = tempQ[tempSel];
                        tempD[tempSel] = accQ;
                    end else begin
                        illNew = 1'b1;
                    end
                end
                OP_CLR: begin
                    accD   = '0;
                    carryD = 1'b0;
                end
                OP_CMC:  carryD = ~carryQ;
                OP_SAVE: ;
                OP_RESTORE: begin
                    if (!saveEmpty) {carryD, accD} = popData;
                end
                default: ;
            endcase
        end
        // A fresh error outranks a simultaneous clear.
        errOvfD = (errOvfQ && !errClr) || ovfNew;
        errUdfD = (errUdfQ && !errClr) || udfNew;
        errIllD = (errIllQ && !errClr) || illNew;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            accQ    <= '0;
            carryQ  <= 1'b0;
            errOvfQ <= 1'b0;
            errUdfQ <= 1'b0;
            errIllQ <= 1'b0;
            for (int i = 0; i < int'(TEMP_DEPTH); i++) tempQ[i] <= '0;
        end else begin
            accQ    <= accD;
            carryQ  <= carryD;
            errOvfQ <= errOvfD;
            errUdfQ <= errUdfD;
            errIllQ <= errIllD;
            tempQ   <= tempD;
        end
    end

    assign accOut   = accQ;
    assign carryOut = carryQ;
    assign tempOut  = tempRd;
    assign accZero  = (accQ == '0);
    assign errOvf   = errOvfQ;
    assign errUdf   = errUdfQ;
    assign errIll   = errIllQ;

endmodule

// File: tb/tb_acc_temp_unit.sv
// Scoreboard bench for acc_temp_unit (DATA_W 4, TEMP_DEPTH 3, SAVE_DEPTH 2).
module tb_acc_temp_unit;

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
        logic [3:0] res;
        logic       c;
        logic [1:0] sel;
        logic       clr;
    } stim_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       opValid, aluCarry, errClr;
    logic [2:0] opCode;
    logic [3:0] aluResult;
    logic [1:0] tempSel;
    logic [3:0] accOut, tempOut;
    logic       carryOut, accZero, saveFull, saveEmpty, errOvf, errUdf, errIll;
    logic [14:0] obs, exp;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] mAcc;
    logic       mCarry, mOvf, mUdf, mIll;
    logic [3:0] mTemp [3];
    logic [4:0] mStack [$];
    logic [14:0] sb [$];

    always #5 clk = ~clk;

    acc_temp_unit #(
        .DATA_W     (4),
        .TEMP_DEPTH (3),
        .SAVE_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .opValid   (opValid),
        .opCode    (opCode),
        .aluResult (aluResult),
        .aluCarry  (aluCarry),
        .tempSel   (tempSel),
        .errClr    (errClr),
        .accOut    (accOut),
        .carryOut  (carryOut),
        .tempOut   (tempOut),
        .accZero   (accZero),
        .saveFull  (saveFull),
        .saveEmpty (saveEmpty),
        .errOvf    (errOvf),
        .errUdf    (errUdf),
        .errIll    (errIll)
    );

    assign obs = {accOut, carryOut, accZero, saveFull, saveEmpty, errOvf, errUdf, errIll,
                  tempOut};

    function automatic stim_t mk(input logic v, input logic [2:0] op, input logic [3:0] r,
                                 input logic c, input logic [1:0] s, input logic clr);
        stim_t t;
        t = '{valid: v, op: op, res: r, c: c, sel: s, clr: clr};
        return t;
    endfunction

    function automatic logic [14:0] expVec(input logic [1:0] sel);
        logic [3:0] t;
        t = (sel < 2'd3) ? mTemp[sel] : 4'h0;
        return {mAcc, mCarry, (mAcc == 4'h0), (mStack.size() == 2), (mStack.size() == 0),
                mOvf, mUdf, mIll, t};
    endfunction

    task automatic modelReset();
        mAcc = '0; mCarry = 0; mOvf = 0; mUdf = 0; mIll = 0;
        for (int i = 0; i < 3; i++) mTemp[i] = '0;
        mStack.delete();
    endtask

    task automatic modelStep(input stim_t s);
        logic o, u, il;
        logic [3:0] t;
        logic [4:0] p;
        o = 0; u = 0; il = 0;
        if (s.valid) begin
            case (s.op)
                3'd1: begin mAcc = s.res; mCarry = s.c; end
                3'd2: if (s.sel < 2'd3) mTemp[s.sel] = s.res; else il = 1;
                3'd3: if (s.sel < 2'd3) begin
                          t = mTemp[s.sel]; mTemp[s.sel] = mAcc; mAcc = t;
                      end else il = 1;
                3'd4: begin mAcc = 0; mCarry = 0; end
                3'd5: mCarry = ~mCarry;
                3'd6: if (mStack.size() == 2) o = 1; else mStack.push_back({mCarry, mAcc});
                3'd7: if (mStack.size() == 0) u = 1;
                      else begin p = mStack.pop_back(); {mCarry, mAcc} = p; end
                default: ;
            endcase
        end
        if (s.clr) begin mOvf = 0; mUdf = 0; mIll = 0; end
        mOvf = mOvf | o; mUdf = mUdf | u; mIll = mIll | il;
    endtask

    task automatic drive(input stim_t s);
        opValid = s.valid; opCode = s.op; aluResult = s.res; aluCarry = s.c;
        tempSel = s.sel; errClr = s.clr;
        @(posedge clk);
        modelStep(s);
        sb.push_back(expVec(s.sel));
        #1;
    endtask

    task automatic test_reset();
        rstN = 0;
        drive(mk(0, 0, 0, 0, 0, 0));
        modelReset();
        void'(sb.pop_back());
        sb.push_back(expVec(2'd0));
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs, exp);
        end
        @(negedge clk);
        rstN = 1;
    endtask

    task automatic test_lda();
        stim_t s [3];
        s = '{mk(1, 1, 4'hA, 1, 0, 0), mk(1, 1, 4'h0, 0, 0, 0), mk(0, 1, 4'h6, 1, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lda[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_xch();
        stim_t s [5];
        s = '{mk(1, 1, 4'h3, 0, 0, 0), mk(1, 2, 4'hC, 0, 2, 0), mk(1, 3, 4'h0, 0, 2, 0),
              mk(1, 0, 4'h0, 0, 2, 0), mk(1, 5, 4'h0, 0, 1, 0)};
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL xch[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_save_stack();
        stim_t s [9];
        s = '{mk(1, 1, 4'h5, 0, 0, 0), mk(1, 6, 4'h0, 0, 0, 0), mk(1, 1, 4'h9, 1, 0, 0),
              mk(1, 6, 4'h0, 0, 0, 0), mk(1, 1, 4'h1, 0, 0, 0), mk(1, 6, 4'h0, 0, 0, 0),
              mk(1, 7, 4'h0, 0, 0, 0), mk(1, 7, 4'h0, 0, 0, 0), mk(0, 0, 4'h0, 0, 0, 1)};
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL save[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_underflow();
        stim_t s [4];
        s = '{mk(1, 1, 4'h7, 1, 0, 0), mk(1, 7, 4'h0, 0, 0, 0), mk(0, 7, 4'h0, 0, 0, 1),
              mk(1, 7, 4'h0, 0, 0, 1)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL udf[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_bad_sel();
        stim_t s [7];
        s = '{mk(1, 4, 4'h0, 0, 0, 1), mk(1, 2, 4'hF, 0, 3, 0), mk(1, 3, 4'h0, 0, 3, 0),
              mk(1, 0, 4'h0, 0, 0, 0), mk(1, 0, 4'h0, 0, 1, 0), mk(1, 0, 4'h0, 0, 2, 0),
              mk(0, 0, 4'h0, 0, 3, 1)};
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ill[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(mk(1, 1, 4'hB, 1, 0, 0));
        drive(mk(1, 6, 4'h0, 0, 0, 0));
        sb.delete();
        opValid = 1; opCode = 3'd6; errClr = 0; tempSel = 0;
        #2 rstN = 0;
        #1;
        modelReset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back(expVec(2'd0));
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got %h want %h", i, obs, exp);
            end
            @(posedge clk);
            #1;
        end
        rstN = 1;
        drive(mk(1, 7, 4'h0, 0, 0, 0));
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_after: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_lda();
        test_xch();
        test_save_stack();
        test_underflow();
        test_bad_sel();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
